// File: rtl/uart_aer_decoder.sv
// Turns the UART byte stream into AER events: assembles 2-byte header/address
// packets and drives each valid address over a 4-phase req/ack handshake.
module uart_aer_decoder #(
   parameter logic [7:0]  MAX_NEUR       = 8'd138,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned ERR_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_tdata,
   input  logic             rx_tvalid,
   output logic             rx_tready,
   output logic [9:0]       aer_addr,
   output logic             aer_req,
   input  logic             aer_ack,
   output logic [ERR_W-1:0] err_cnt,
   output logic             busy
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADDR    = 2'd1,
      REQ     = 2'd2,
      RELEASE = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         hi_q, hi_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [9:0]         addr_q, addr_d;
   logic               req_q, req_d;
   logic               tready_q, tready_d;
   logic               busy_q, busy_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               err_inc;
   logic               transfer;
   logic               header_ok;
   logic               out_of_range;

   assign transfer     = rx_tvalid & tready_q;
   assign header_ok    = (rx_tdata[7:4] == 4'b0010) && (rx_tdata[3:2] == 2'b00);
   // Only plain neuron events (hi == 0) are range-checked; time-ref and config pass through.
   assign out_of_range = (hi_q == 2'b00) && (rx_tdata >= MAX_NEUR);

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      timer_d = timer_q;
      addr_d  = addr_q;
      req_d   = req_q;
      err_inc = 1'b0;

      case (state_q)
         IDLE: begin
            if (transfer) begin
               if (header_ok) begin
                  hi_d    = rx_tdata[1:0];
                  timer_d = '0;
                  state_d = ADDR;
               end else begin
                  err_inc = 1'b1;
               end
            end
         end
         ADDR: begin
            // A byte arriving on the timeout cycle still completes the packet.
            if (transfer) begin
               if (out_of_range) begin
                  err_inc = 1'b1;
                  state_d = IDLE;
               end else begin
                  addr_d  = {hi_q, rx_tdata};
                  req_d   = 1'b1;
                  state_d = REQ;
               end
            end else if (timer_q == TMR_LAST) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         REQ: begin
            if (aer_ack) begin
               req_d   = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!aer_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase

      err_d    = (err_inc && (err_q != '1)) ? (err_q + ERR_W'(1)) : err_q;
      tready_d = (state_d == IDLE) || (state_d == ADDR);
      busy_d   = (state_d != IDLE);
   end

   // State and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         hi_q     <= 2'b00;
         timer_q  <= '0;
         addr_q   <= '0;
         req_q    <= 1'b0;
         tready_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         timer_q  <= timer_d;
         addr_q   <= addr_d;
         req_q    <= req_d;
         tready_q <= tready_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign rx_tready = tready_q;
   assign aer_addr  = addr_q;
   assign aer_req   = req_q;
   assign err_cnt   = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_aer_decoder.sv
// Directed-vector bench for uart_aer_decoder with a short timeout so the
// header-timeout path can be exercised in a few cycles.
module tb_uart_aer_decoder;

   localparam int unsigned TMO   = 50;
   localparam int unsigned ERR_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       rx_tdata;
   logic             rx_tvalid;
   logic             rx_tready;
   logic [9:0]       aer_addr;
   logic             aer_req;
   logic             aer_ack;
   logic [ERR_W-1:0] err_cnt;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   uart_aer_decoder #(
      .MAX_NEUR       (8'd138),
      .TIMEOUT_CYCLES (TMO),
      .ERR_W          (ERR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_tdata  (rx_tdata),
      .rx_tvalid (rx_tvalid),
      .rx_tready (rx_tready),
      .aer_addr  (aer_addr),
      .aer_req   (aer_req),
      .aer_ack   (aer_ack),
      .err_cnt   (err_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst       = 1'b0;
      aer_ack   = 1'b0;
      rx_tvalid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Offers one byte and returns on the negedge after it was accepted.
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      rx_tdata  = b;
      rx_tvalid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (rx_tready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         rx_tvalid = 1'b0;
         check_eq("send_timeout", 32'(0), 32'(1));
      end else begin
         @(posedge clk);
         @(negedge clk);
         rx_tvalid = 1'b0;
      end
   endtask

   // Waits for aer_req, raises ack ack_dly cycles later, counts req-high cycles.
   task automatic do_event(input int ack_dly, output logic [9:0] addr, output int hi_cyc,
                           output bit got);
      got    = 1'b0;
      hi_cyc = 0;
      addr   = '0;
      for (int i = 0; i < 100; i++) begin
         if (aer_req) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (got) begin
         addr   = aer_addr;
         hi_cyc = 1;
         for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            if (aer_req) hi_cyc++;
         end
         aer_ack = 1'b1;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (aer_req) hi_cyc++;
            else break;
         end
         aer_ack = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic expect_event(input string tag, input int ack_dly, input logic [9:0] exp_addr);
      logic [9:0] a;
      int         h;
      bit         g;
      do_event(ack_dly, a, h, g);
      check_eq({tag, "_req_seen"}, 32'(g), 32'(1));
      check_eq({tag, "_addr"}, 32'(a), 32'(exp_addr));
   endtask

   task automatic expect_no_req(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (aer_req) seen = 1'b1;
      end
      check_eq(tag, 32'(seen), 32'(0));
   endtask

   initial begin
      logic [9:0] a;
      int         h;
      bit         g;

      rst       = 1'b0;
      rx_tdata  = 8'h00;
      rx_tvalid = 1'b0;
      aer_ack   = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_tready", 32'(rx_tready), 32'(0));
      check_eq("rst_req", 32'(aer_req), 32'(0));
      check_eq("rst_addr", 32'(aer_addr), 32'(0));
      check_eq("rst_err", 32'(err_cnt), 32'(0));
      check_eq("rst_busy", 32'(busy), 32'(0));
      rst = 1'b1;
      @(negedge clk);
      check_eq("tready_after_rst", 32'(rx_tready), 32'(1));

      // Basic event, ack three cycles after req
      send_byte(8'h20);
      check_eq("busy_in_addr", 32'(busy), 32'(1));
      send_byte(8'h05);
      do_event(3, a, h, g);
      check_eq("t1_req_seen", 32'(g), 32'(1));
      check_eq("t1_addr", 32'(a), 32'h005);
      check_eq("t1_req_cycles", 32'(h), 32'(4));
      check_eq("t1_err", 32'(err_cnt), 32'(0));
      check_eq("t1_idle", 32'(busy), 32'(0));

      // Time-reference event bypasses range check
      send_byte(8'h21);
      send_byte(8'hFF);
      expect_event("t2", 1, 10'h1FF);

      // Reserved/config header forwarded unchanged
      send_byte(8'h22);
      send_byte(8'h34);
      expect_event("cfg", 2, 10'h234);

      // Bad header dropped, following packet still decoded
      reset_dut();
      send_byte(8'h30);
      check_eq("t3_err", 32'(err_cnt), 32'(1));
      check_eq("t3_busy", 32'(busy), 32'(0));
      send_byte(8'h20);
      send_byte(8'h07);
      expect_event("t3", 1, 10'h007);

      // Range boundary: 138 rejected, 137 accepted
      reset_dut();
      send_byte(8'h20);
      send_byte(8'h8A);
      expect_no_req("t4_no_req");
      check_eq("t4_err", 32'(err_cnt), 32'(1));
      check_eq("t4_busy", 32'(busy), 32'(0));
      send_byte(8'h20);
      send_byte(8'h89);
      expect_event("t4", 1, 10'h089);
      check_eq("t4_err_after", 32'(err_cnt), 32'(1));

      // Header timeout boundary
      reset_dut();
      send_byte(8'h20);
      repeat (TMO - 1) @(negedge clk);
      check_eq("t5_busy_before_tmo", 32'(busy), 32'(1));
      check_eq("t5_err_before_tmo", 32'(err_cnt), 32'(0));
      @(negedge clk);
      check_eq("t5_busy_after_tmo", 32'(busy), 32'(0));
      check_eq("t5_err_after_tmo", 32'(err_cnt), 32'(1));
      send_byte(8'h20);
      send_byte(8'h01);
      expect_event("t5", 1, 10'h001);

      // Reset during handshake with ack low
      reset_dut();
      send_byte(8'hFF);
      send_byte(8'h20);
      send_byte(8'h05);
      check_eq("t6_req_up", 32'(aer_req), 32'(1));
      check_eq("t6_err_pre", 32'(err_cnt), 32'(1));
      rst = 1'b0;
      @(negedge clk);
      check_eq("t6_req_dropped", 32'(aer_req), 32'(0));
      check_eq("t6_err_cleared", 32'(err_cnt), 32'(0));
      check_eq("t6_tready_in_rst", 32'(rx_tready), 32'(0));
      rst = 1'b1;
      @(negedge clk);

      // Error counter saturation
      repeat (254) send_byte(8'hFF);
      check_eq("sat_254", 32'(err_cnt), 32'(254));
      send_byte(8'hFF);
      check_eq("sat_255", 32'(err_cnt), 32'(255));
      repeat (45) send_byte(8'hFF);
      check_eq("sat_300", 32'(err_cnt), 32'(255));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
